// File: rtl/dp_pkg.sv
// dp_pkg: shared types, opcode/condition/shift constants and condition evaluation for dp_sequencer
package dp_pkg;
    typedef enum logic [2:0] {S_IDLE, S_READ, S_RSHIFT, S_EXEC, S_WB} state_t;
    localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
                           OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
                           OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
                           OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;
    localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
                           CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
                           CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
                           CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF;
    localparam logic [2:0] SH_LSL = 3'd0, SH_LSR = 3'd1, SH_ASR = 3'd2, SH_ROR = 3'd3;
    // Odd codes are the negation of the even code below them; AL/NV pair as always/never.
    function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
        logic b;
        case ({cc[3:1], 1'b0})
            CC_EQ: b = f[2];
            CC_CS: b = f[1];
            CC_MI: b = f[3];
            CC_VS: b = f[0];
            CC_HI: b = f[1] & ~f[2];
            CC_GE: b = f[3] == f[0];
            CC_GT: b = ~f[2] & (f[3] == f[0]);
            default: b = 1'b1;
        endcase
        return b ^ cc[0];
    endfunction
endpackage

// File: rtl/dp_alu.sv
// dp_alu: combinational data-processing ALU producing result and NZCV
module dp_alu
    import dp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      opcode,
    input  logic            c_in,
    input  logic            v_in,
    output logic [XLEN-1:0] result,
    output logic [3:0]      nzcv
);
    logic [XLEN-1:0] x, y, lres;
    logic [XLEN:0] sum;
    logic ci, arith;
    // All arithmetic is x + y + ci; subtraction inverts an operand so carry is NOT borrow.
    always_comb begin
        x = a;
        y = b;
        ci = 1'b0;
        arith = 1'b1;
        case (opcode)
            OP_SUB, OP_CMP: begin y = ~b; ci = 1'b1; end
            OP_RSB: begin x = b; y = ~a; ci = 1'b1; end
            OP_ADD, OP_CMN: ci = 1'b0;
            OP_ADC: ci = c_in;
            OP_SBC: begin y = ~b; ci = c_in; end
            OP_RSC: begin x = b; y = ~a; ci = c_in; end
            default: arith = 1'b0;
        endcase
        case (opcode)
            OP_AND, OP_TST: lres = a & b;
            OP_EOR, OP_TEQ: lres = a ^ b;
            OP_ORR: lres = a | b;
            OP_BIC: lres = a & ~b;
            OP_MVN: lres = ~b;
            default: lres = b;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {{XLEN{1'b0}}, ci};
        result = arith ? sum[XLEN-1:0] : lres;
        nzcv = {result[XLEN-1], ~|result, arith ? sum[XLEN] : c_in,
                arith ? (x[XLEN-1] == y[XLEN-1]) && (sum[XLEN-1] != x[XLEN-1]) : v_in};
    end
endmodule

// File: rtl/dp_sequencer.sv
// dp_sequencer: multi-cycle data-processing instruction sequencer with condition codes and register shifts
module dp_sequencer
    import dp_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RAW  = 4,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [RAW-1:0]  rf_raddr1,
    output logic [RAW-1:0]  rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic            rf_we,
    output logic [RAW-1:0]  rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [XLEN-1:0] sh_in,
    output logic [2:0]      sh_mode,
    output logic [SHW-1:0]  sh_count,
    input  logic [XLEN-1:0] sh_out,
    input  logic [3:0]      flags_in,
    output logic            cpsr_we,
    output logic [3:0]      cpsr_wdata,
    output logic            done,
    output logic            err
);
    state_t state_q, state_d;
    logic [25:0] ir;
    logic [XLEN-1:0] rn_q, rm_q, res_q, op2, alu_res;
    logic [7:0] rs_q;
    logic [3:0] nzcv_q, alu_nzcv;
    logic err_q, skip_q, imm, reg_sh, is_test, bad, big;
    assign imm = ir[25];
    assign reg_sh = ~ir[25] & ir[4];
    assign is_test = ir[24:23] == 2'b10;
    assign bad = (instr[27:26] != 2'b00) | (~instr[25] & instr[4] & instr[7]);
    assign big = int'(rs_q) >= XLEN;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (instr_valid) state_d = (bad || !cond_pass(instr[31:28], flags_in)) ? S_WB : S_READ;
            S_READ: state_d = reg_sh ? S_RSHIFT : S_EXEC;
            S_RSHIFT: state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            default: state_d = S_IDLE;
        endcase
    end
    // Shifter is held driven through EXEC so sh_out is still valid when op2 is captured.
    always_comb begin
        rf_raddr1 = '0;
        rf_raddr2 = '0;
        sh_in = '0;
        sh_mode = '0;
        sh_count = '0;
        if (state_q == S_READ) begin
            rf_raddr1 = RAW'(ir[19:16]);
            rf_raddr2 = RAW'(ir[3:0]);
        end
        if (state_q == S_RSHIFT) rf_raddr2 = RAW'(ir[11:8]);
        if (state_q inside {S_READ, S_RSHIFT, S_EXEC}) begin
            sh_in = imm ? XLEN'(ir[7:0]) : (state_q == S_READ ? rf_rdata2 : rm_q);
            sh_mode = imm ? SH_ROR : {1'b0, ir[6:5]};
            sh_count = imm ? SHW'({ir[11:8], 1'b0}) : reg_sh ? rs_q[SHW-1:0] : SHW'(ir[11:7]);
        end
    end
    // Register-specified amounts of zero or >= XLEN bypass the external shifter.
    assign op2 = !reg_sh ? sh_out :
                 rs_q == 8'd0 ? rm_q :
                 !big ? sh_out :
                 ir[6:5] == 2'b10 ? {XLEN{rm_q[XLEN-1]}} :
                 ir[6] ? sh_out : '0;
    dp_alu #(.XLEN(XLEN)) u_alu (
        .a(rn_q),
        .b(op2),
        .opcode(ir[24:21]),
        .c_in(flags_in[1]),
        .v_in(flags_in[0]),
        .result(alu_res),
        .nzcv(alu_nzcv)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= '0;
            err_q <= 1'b0;
            skip_q <= 1'b0;
            rn_q <= '0;
            rm_q <= '0;
            rs_q <= '0;
            res_q <= '0;
            nzcv_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (instr_valid) begin
                    ir <= instr[25:0];
                    err_q <= bad;
                    skip_q <= ~bad & ~cond_pass(instr[31:28], flags_in);
                end
                S_READ: begin
                    rn_q <= rf_rdata1;
                    rm_q <= rf_rdata2;
                end
                S_RSHIFT: rs_q <= rf_rdata2[7:0];
                S_EXEC: begin
                    res_q <= alu_res;
                    nzcv_q <= alu_nzcv;
                end
                default: ;
            endcase
        end
    end
    assign instr_ready = state_q == S_IDLE;
    assign done = state_q == S_WB;
    assign err = done & err_q;
    assign rf_we = done & ~err_q & ~skip_q & ~is_test;
    assign cpsr_we = done & ~err_q & ~skip_q & (ir[20] | is_test);
    assign rf_waddr = RAW'(ir[15:12]);
    assign rf_wdata = res_q;
    assign cpsr_wdata = nzcv_q;
endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer: scoreboard bench with register-bank, shifter and CPSR models around dp_sequencer
module tb_dp_sequencer;
    logic clk = 1'b0, rst = 1'b1;
    logic instr_valid = 1'b0, instr_ready;
    logic [31:0] instr = '0;
    logic [3:0] rf_raddr1, rf_raddr2, rf_waddr;
    logic [31:0] rf_rdata1, rf_rdata2, rf_wdata, sh_in, sh_out;
    logic rf_we, cpsr_we, done, err;
    logic [2:0] sh_mode;
    logic [4:0] sh_count;
    logic [3:0] flags = '0, cpsr_wdata;
    logic [31:0] rf [16];
    logic ld = 1'b0, ldf = 1'b0;
    logic [3:0] ld_idx = '0, ldf_val = '0;
    logic [31:0] ld_val = '0;
    int n_checks = 0, n_fail = 0, cyc = 0, acc = 0;
    typedef struct {
        int id;
        int lat;
        logic we;
        logic [3:0] wa;
        logic [31:0] wd;
        logic cwe;
        logic [3:0] nz;
        logic er;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    dp_sequencer dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .sh_in(sh_in), .sh_mode(sh_mode), .sh_count(sh_count), .sh_out(sh_out),
        .flags_in(flags), .cpsr_we(cpsr_we), .cpsr_wdata(cpsr_wdata), .done(done), .err(err)
    );

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];
    always_comb begin
        case (sh_mode)
            3'd0: sh_out = sh_in << sh_count;
            3'd1: sh_out = sh_in >> sh_count;
            3'd2: sh_out = $signed(sh_in) >>> sh_count;
            3'd3: sh_out = (sh_in >> sh_count) | (sh_in << (6'd32 - {1'b0, sh_count}));
            default: sh_out = sh_in;
        endcase
    end
    always @(posedge clk) begin
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        if (ld) rf[ld_idx] <= ld_val;
        if (cpsr_we) flags <= cpsr_wdata;
        if (ldf) flags <= ldf_val;
    end
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (instr_valid && instr_ready) acc <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) check("unexpected_done", 32'(sb.size()), 32'd1);
            else begin
                mon_e = sb.pop_front();
                check($sformatf("t%0d_latency", mon_e.id), 32'(cyc - acc), 32'(mon_e.lat));
                check($sformatf("t%0d_err", mon_e.id), 32'(err), 32'(mon_e.er));
                check($sformatf("t%0d_rf_we", mon_e.id), 32'(rf_we), 32'(mon_e.we));
                check($sformatf("t%0d_cpsr_we", mon_e.id), 32'(cpsr_we), 32'(mon_e.cwe));
                if (mon_e.we) begin
                    check($sformatf("t%0d_waddr", mon_e.id), 32'(rf_waddr), 32'(mon_e.wa));
                    check($sformatf("t%0d_wdata", mon_e.id), rf_wdata, mon_e.wd);
                end
                if (mon_e.cwe) check($sformatf("t%0d_nzcv", mon_e.id), 32'(cpsr_wdata), 32'(mon_e.nz));
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !instr_ready) && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("wait_idle", 32'(sb.size()), 32'd0);
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] v);
        wait_idle();
        ld = 1'b1;
        ld_idx = idx;
        ld_val = v;
        @(posedge clk);
        #1 ld = 1'b0;
    endtask

    task automatic set_flags(input logic [3:0] v);
        wait_idle();
        ldf = 1'b1;
        ldf_val = v;
        @(posedge clk);
        #1 ldf = 1'b0;
    endtask

    task automatic issue(input int id, input logic [31:0] ins, input int lat, input logic we,
                         input logic [3:0] wa, input logic [31:0] wd, input logic cwe,
                         input logic [3:0] nz, input logic er);
        exp_t e;
        wait_idle();
        e.id = id; e.lat = lat; e.we = we; e.wa = wa; e.wd = wd; e.cwe = cwe; e.nz = nz; e.er = er;
        sb.push_back(e);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        #1;
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_cpsr_we", 32'(cpsr_we), 32'd0);
        check("rst_sh_in", sh_in, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        preload(4'd0, 32'hFFFF_FFF0);
        preload(4'd1, 32'h0000_000F);
        preload(4'd2, 32'd4);
        preload(4'd7, 32'h8000_0000);
        preload(4'd13, 32'h55);
        set_flags(4'b0000);
        issue(1, 32'hE290_000F, 3, 1'b1, 4'd0, 32'hFFFF_FFFF, 1'b1, 4'b1000, 1'b0);
        preload(4'd0, 32'hFFFF_FFF0);
        set_flags(4'b0000);
        issue(2, 32'hE090_0001, 3, 1'b1, 4'd0, 32'hFFFF_FFFF, 1'b1, 4'b1000, 1'b0);
        issue(3, 32'hE081_3211, 4, 1'b1, 4'd3, 32'h0000_00FF, 1'b0, 4'b0000, 1'b0);
        issue(4, 32'hE151_0001, 3, 1'b0, 4'd0, 32'h0, 1'b1, 4'b0110, 1'b0);
        issue(5, 32'h0281_4001, 3, 1'b1, 4'd4, 32'h0000_0010, 1'b0, 4'b0000, 1'b0);
        issue(6, 32'h1281_5001, 1, 1'b0, 4'd0, 32'h0, 1'b0, 4'b0000, 1'b0);
        preload(4'd2, 32'd40);
        set_flags(4'b0000);
        issue(7, 32'hE1B0_6231, 4, 1'b1, 4'd6, 32'h0, 1'b1, 4'b0100, 1'b0);
        issue(8, 32'hE1A0_8257, 4, 1'b1, 4'd8, 32'hFFFF_FFFF, 1'b0, 4'b0000, 1'b0);
        issue(9, 32'hE001_0291, 1, 1'b0, 4'd0, 32'h0, 1'b0, 4'b0000, 1'b1);
        issue(10, 32'hE251_9010, 3, 1'b1, 4'd9, 32'hFFFF_FFFF, 1'b1, 4'b1000, 1'b0);
        issue(11, 32'hE3A0_A4FF, 3, 1'b1, 4'd10, 32'hFF00_0000, 1'b0, 4'b0000, 1'b0);
        set_flags(4'b0011);
        issue(12, 32'hE211_B0F0, 3, 1'b1, 4'd11, 32'h0, 1'b1, 4'b0111, 1'b0);
        set_flags(4'b0010);
        issue(13, 32'hE0B1_C001, 3, 1'b1, 4'd12, 32'h0000_001F, 1'b1, 4'b0000, 1'b0);
        wait_idle();
        check("model_r3", rf[3], 32'h0000_00FF);
        check("model_flags", 32'(flags), 32'd0);
        instr = 32'hE281_D001;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_ready", 32'(instr_ready), 32'd1);
        check("midrst_rf_we", 32'(rf_we), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_r13", rf[13], 32'h55);
        check("midrst_idle", 32'(instr_ready), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dp_sequencer.md
# dp_sequencer

Multi-cycle sequencer for the data-processing instruction class: accepts one 32-bit instruction over a valid/ready handshake, reads operands from the register bank and drives the external barrel shifter. It performs the ALU operation internally, writes back the destination register, and updates NZCV. Unlike the single-pass datapath sequencing, it evaluates condition codes, resolves register-specified shifts (Rs) in a dedicated extra cycle, and is parametrised in data and register-address width.

## Interface
- XLEN, 32, datapath width.
- RAW, 4, register-address width (16 registers).
- SHW, 5, shifter count width; equals log2(XLEN).

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  high only in IDLE.
- instr  in  32  ARM-format instruction.
- rf_raddr1, rf_raddr2  out  RAW  register-bank read addresses.
- rf_rdata1, rf_rdata2  in  XLEN  combinational read data (same cycle).
- rf_we  out  1  write enable, one cycle.
- rf_waddr  out  RAW  write address (Rd).
- rf_wdata  out  XLEN  write data.
- sh_in  out  XLEN  shifter operand.
- sh_mode  out  3  0 LSL, 1 LSR, 2 ASR, 3 ROR, 4-7 reserved.
- sh_count  out  SHW  shift amount.
- sh_out  in  XLEN  combinational shifter result.
- flags_in  in  4  current CPSR {N,Z,C,V}.
- cpsr_we  out  1  flag write strobe.
- cpsr_wdata  out  4  new {N,Z,C,V}.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done, for an unsupported instruction.

## Operation
- States: IDLE, READ, RSHIFT, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid, latch instr.
  - instr[27:26]≠00, or I=0 with bit4=1 and bit7=1 (multiply/extension space): next WB with err, no writes.
  - Condition (instr[31:28], full ARM table on flags_in) fails: next WB, no writes, err=0.
  - Otherwise: READ.
- READ: rf_raddr1=Rn, rf_raddr2=Rm; latch both.
  - I=1: sh_in=zero-extended imm8, sh_mode=ROR, sh_count=2·rot.
  - I=0, bit4=0: sh_in=Rm, mode=instr[6:5], count=instr[11:7].
  - I=0, bit4=1: next RSHIFT; otherwise next EXEC.
- RSHIFT: rf_raddr2=Rs; amount a=rdata2[7:0].
  - a=0: pass Rm unshifted.
  - a≥XLEN with LSL/LSR: operand 0.
  - a≥XLEN with ASR: all sign bits.
  - ROR: count a[SHW-1:0].
  - Next EXEC.
- EXEC: capture sh_out (or override) as op2 and compute the ALU result from the latched Rn.
  - All 16 opcodes.
  - MOV/MVN ignore Rn.
  - ADC/SBC/RSC use flags_in.C.
  - Subtract C = NOT borrow.
  - Logical ops keep C and V from flags_in.
  - Result truncated to XLEN.
- WB: done=1.
  - rf_we=1 unless TST/TEQ/CMP/CMN, a failed condition, or err.
  - cpsr_we=1 if S=1, or always for TST/TEQ/CMP/CMN; not asserted on a failed condition or err.
  - Rd=15 is written as an ordinary register.
  - Next IDLE.

## Timing
- Reset: state IDLE, instr_ready=1, all other outputs 0; effective immediately (asynchronous).
- Reset mid-instruction: rf_we and cpsr_we drop at once; no partial writeback.
- Latency, accept edge = cycle 0, done in cycle n:
  - immediate or immediate-shift: n=3.
  - register shift: n=4.
  - failed condition or err: n=1.
- Throughput: the next instruction is accepted at the earliest in the cycle after done; instr_valid is ignored outside IDLE.
- Register data is sampled at the end of READ/RSHIFT. The bank must not be written externally during a sequence.

## Structure
- dp_pkg holds:
  - state enum;
  - opcode constants AND…MVN;
  - condition-code constants;
  - shift-mode constants.
- Sub-module dp_alu (combinational: a, b, opcode, flags_in → result, NZCV).
- The condition-evaluation function lives in dp_pkg.

## Test plan
- r0=0xFFFFFFF0, flags 0; ADDS r0,r0,#0x0F: done at cycle 3, rf_wdata=0xFFFFFFFF, NZCV=1000.
- r0=0xFFFFFFF0, r1=0xF; ADDS r0,r0,r1 (LSL #0): same result, cycle 3.
- r1=0xF, r2=4; ADD r3,r1,r1 LSL r2: done at cycle 4, r3=0xFF, cpsr_we=0.
- CMP r1,r1 with r1=0xF: rf_we=0, cpsr_we=1, NZCV=0110. Then ADDEQ runs; ADDNE gives done at cycle 1, no writes.
- Register shift LSR by Rs=40 → operand 0. Shift ASR by Rs=40 on 0x80000000 → 0xFFFFFFFF.
- Unsupported instruction 0xE0010291 (MUL): done+err at cycle 1, no writes. Reset asserted during EXEC: instr_ready=1 at once, no rf_we.
